// File: rtl/pe_ctl_seq_pkg.sv
// rtl/pe_ctl_seq_pkg.sv - shared PE sequencer types (psum mode, control token, FSM states)
package pe_ctl_seq_pkg;

    localparam int PE_TAPW = 4;
    localparam int PE_OUTW = 8;

    typedef enum logic {
        PSUM_D8  = 1'b0,
        PSUM_D16 = 1'b1
    } pe_psum_mode_e;

    typedef struct packed {
        logic [PE_OUTW-1:0] out_idx;
        logic [PE_TAPW-1:0] tap_idx;
        pe_psum_mode_e      psum_mode;
        logic               psum_parity;
        logic               first;
        logic               last;
        logic               psum_zero;
    } pe_seq_tok_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } pe_seq_state_e;

endpackage

// File: rtl/pe_seq_cnt.sv
// rtl/pe_seq_cnt.sv - nested out/parity/tap counter holding the currently presented token
module pe_seq_cnt #(
    parameter int TAPW = 4,
    parameter int OUTW = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            load,
    input  logic            adv,
    input  logic [TAPW-1:0] num_tap,
    input  logic [OUTW-1:0] num_out,
    input  logic            mode_d16,
    input  logic            psum_init,
    output logic [TAPW-1:0] tap_idx,
    output logic [OUTW-1:0] out_idx,
    output logic            parity,
    output logic            d16,
    output logic            first,
    output logic            last,
    output logic            psum_zero,
    output logic            final_tok
);

    logic [TAPW-1:0] ntap;
    logic [OUTW-1:0] nout;
    logic            init_q;
    logic [TAPW-1:0] tap_nxt;
    logic [OUTW-1:0] out_nxt;
    logic            par_nxt;
    logic            tap_end;
    logic            par_end;

    // Flags are registered alongside the indices so the token is fully flopped.
    always_comb begin
        tap_end = (tap_idx == ntap);
        par_end = !d16 || parity;
        tap_nxt = tap_end ? '0 : tap_idx + 1'b1;
        par_nxt = parity;
        out_nxt = out_idx;
        if (tap_end) begin
            par_nxt = par_end ? 1'b0 : 1'b1;
            if (par_end) begin
                out_nxt = (out_idx == nout) ? '0 : out_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ntap      <= '0;
            nout      <= '0;
            d16       <= 1'b0;
            init_q    <= 1'b0;
            tap_idx   <= '0;
            out_idx   <= '0;
            parity    <= 1'b0;
            first     <= 1'b0;
            last      <= 1'b0;
            psum_zero <= 1'b0;
            final_tok <= 1'b0;
        end else if (load) begin
            ntap      <= num_tap;
            nout      <= num_out;
            d16       <= mode_d16;
            init_q    <= psum_init;
            tap_idx   <= '0;
            out_idx   <= '0;
            parity    <= 1'b0;
            first     <= 1'b1;
            last      <= (num_tap == '0);
            psum_zero <= psum_init;
            final_tok <= (num_tap == '0) && (num_out == '0) && !mode_d16;
        end else if (adv) begin
            tap_idx   <= tap_nxt;
            out_idx   <= out_nxt;
            parity    <= par_nxt;
            first     <= (tap_nxt == '0);
            last      <= (tap_nxt == ntap);
            psum_zero <= (tap_nxt == '0) && init_q;
            final_tok <= (tap_nxt == ntap) && (par_nxt == d16) && (out_nxt == nout);
        end
    end

endmodule

// File: rtl/pe_ctl_seq.sv
// rtl/pe_ctl_seq.sv - per-pass PE control token sequencer with credit-bounded issue and drain
module pe_ctl_seq
    import pe_ctl_seq_pkg::*;
#(
    parameter int TAPW   = PE_TAPW,
    parameter int OUTW   = PE_OUTW,
    parameter int MAXOUT = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            cfg_rdy,
    output logic            cfg_ack,
    input  logic [TAPW-1:0] i_num_tap,
    input  logic [OUTW-1:0] i_num_out,
    input  logic            i_psum_mode,
    input  logic            i_psum_init,
    output logic            ctl_rdy,
    input  logic            ctl_ack,
    output pe_seq_tok_t     o_ctl,
    input  logic            i_retire,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    localparam int CW = $clog2(MAXOUT + 1);

    pe_seq_state_e   state;
    logic [CW-1:0]   outst;
    logic [CW-1:0]   outst_nxt;
    logic            xfer;
    logic            err_set;
    logic            cnt_load;
    logic [TAPW-1:0] cnt_tap;
    logic [OUTW-1:0] cnt_out;
    logic            cnt_par;
    logic            cnt_d16;
    logic            cnt_first;
    logic            cnt_last;
    logic            cnt_zero;
    logic            cnt_final;

    assign cfg_ack  = (state == ST_IDLE);
    assign o_busy   = (state != ST_IDLE);
    assign xfer     = ctl_rdy && ctl_ack;
    assign cnt_load = (state == ST_IDLE) && cfg_rdy;

    // Credit update; a retire with nothing outstanding is an error, not an underflow.
    always_comb begin
        outst_nxt = outst;
        err_set   = 1'b0;
        if (xfer && !i_retire) begin
            outst_nxt = outst + 1'b1;
        end else if (!xfer && i_retire) begin
            if (outst == '0) begin
                err_set = 1'b1;
            end else begin
                outst_nxt = outst - 1'b1;
            end
        end
    end

    pe_seq_cnt #(
        .TAPW (TAPW),
        .OUTW (OUTW)
    ) u_cnt (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .load      (cnt_load),
        .adv       (xfer),
        .num_tap   (i_num_tap),
        .num_out   (i_num_out),
        .mode_d16  (i_psum_mode),
        .psum_init (i_psum_init),
        .tap_idx   (cnt_tap),
        .out_idx   (cnt_out),
        .parity    (cnt_par),
        .d16       (cnt_d16),
        .first     (cnt_first),
        .last      (cnt_last),
        .psum_zero (cnt_zero),
        .final_tok (cnt_final)
    );

    assign o_ctl.out_idx     = cnt_out;
    assign o_ctl.tap_idx     = cnt_tap;
    assign o_ctl.psum_mode   = pe_psum_mode_e'(cnt_d16);
    assign o_ctl.psum_parity = cnt_par;
    assign o_ctl.first       = cnt_first;
    assign o_ctl.last        = cnt_last;
    assign o_ctl.psum_zero   = cnt_zero;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            outst   <= '0;
            ctl_rdy <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            outst  <= outst_nxt;
            if (err_set) begin
                o_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (cfg_rdy) begin
                        state   <= ST_RUN;
                        outst   <= '0;
                        ctl_rdy <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (xfer && cnt_final) begin
                        state   <= ST_DRAIN;
                        ctl_rdy <= 1'b0;
                    end else begin
                        ctl_rdy <= (outst_nxt < CW'(MAXOUT));
                    end
                end
                ST_DRAIN: begin
                    if (outst_nxt == '0) begin
                        state  <= ST_IDLE;
                        o_done <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ctl_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_ctl_seq.sv
// tb/tb_pe_ctl_seq.sv - self-checking bench for pe_ctl_seq against a token-list and credit model
module tb_pe_ctl_seq;
    import pe_ctl_seq_pkg::*;

    localparam int MAXOUT = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        cfg_rdy = 1'b0;
    logic        cfg_ack;
    logic [3:0]  i_num_tap = '0;
    logic [7:0]  i_num_out = '0;
    logic        i_psum_mode = 1'b0;
    logic        i_psum_init = 1'b0;
    logic        ctl_rdy;
    logic        ctl_ack = 1'b0;
    pe_seq_tok_t o_ctl;
    logic        i_retire = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;

    pe_ctl_seq #(.TAPW(4), .OUTW(8), .MAXOUT(MAXOUT)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .cfg_rdy     (cfg_rdy),
        .cfg_ack     (cfg_ack),
        .i_num_tap   (i_num_tap),
        .i_num_out   (i_num_out),
        .i_psum_mode (i_psum_mode),
        .i_psum_init (i_psum_init),
        .ctl_rdy     (ctl_rdy),
        .ctl_ack     (ctl_ack),
        .o_ctl       (o_ctl),
        .i_retire    (i_retire),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Whole-pass token list straight from the loop-order rules.
    task automatic build_tokens(input int nt, input int no, input int md, input int init,
                                output pe_seq_tok_t q[$]);
        pe_seq_tok_t t;
        q = {};
        for (int o = 0; o <= no; o++) begin
            for (int p = 0; p < (md ? 2 : 1); p++) begin
                for (int k = 0; k <= nt; k++) begin
                    t.out_idx     = 8'(o);
                    t.tap_idx     = 4'(k);
                    t.psum_mode   = pe_psum_mode_e'(md[0]);
                    t.psum_parity = p[0];
                    t.first       = (k == 0);
                    t.last        = (k == nt);
                    t.psum_zero   = (k == 0) && (init != 0);
                    q.push_back(t);
                end
            end
        end
    endtask

    // rmode: 0 = retire a fixed rpar cycles after each transfer, 1 = random retire rpar%, 2 = credit script
    task automatic run_pass(input int nt, input int no, input int md, input int init,
                            input int rmode, input int ack_pct, input int rpar);
        pe_seq_tok_t exp_q[$];
        int rq[$];
        int issued = 0;
        int outst = 0;
        int cyc = 0;
        int exp_rdy = 1;
        int drain = 0;
        int done_next = 0;
        int ack, ret, xfer, was_drain;
        build_tokens(nt, no, md, init, exp_q);
        checks++;
        if (cfg_ack !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ack_idle: got %b want 1", cfg_ack);
        end
        cfg_rdy = 1'b1;
        i_num_tap = 4'(nt);
        i_num_out = 8'(no);
        i_psum_mode = md[0];
        i_psum_init = init[0];
        ctl_ack = 1'b0;
        i_retire = 1'b0;
        @(negedge i_clk);
        cfg_rdy = 1'b0;
        while (!done_next && cyc < 2000) begin
            checks++;
            if (ctl_rdy !== exp_rdy[0]) begin
                errors++;
                $display("FAIL ctl_rdy cyc=%0d: got %b want %0d", cyc, ctl_rdy, exp_rdy);
            end
            if (exp_rdy != 0) begin
                checks++;
                if (o_ctl !== exp_q[issued]) begin
                    errors++;
                    $display("FAIL token %0d: got %h want %h", issued, o_ctl, exp_q[issued]);
                end
            end
            checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b1 || o_err !== exp_err[0]) begin
                errors++;
                $display("FAIL run_flags cyc=%0d: done=%b busy=%b err=%b want 0 1 %0d", cyc, o_done, o_busy, o_err, exp_err);
            end
            ack = (rmode == 2) ? 1 : (($urandom % 100) < ack_pct);
            ret = 0;
            if (rmode == 0) begin
                if (rq.size() > 0 && rq[0] == cyc) begin
                    ret = 1;
                    void'(rq.pop_front());
                end
            end else if (rmode == 1) begin
                ret = (outst > 0) && (($urandom % 100) < rpar);
            end else begin
                ret = (outst > 0) && (cyc == 8 || cyc == 10 || cyc == 11 || cyc >= 14);
            end
            ctl_ack = ack[0];
            i_retire = ret[0];
            xfer = exp_rdy & ack;
            was_drain = drain;
            outst = outst + xfer - ret;
            if (xfer != 0) begin
                issued++;
                rq.push_back(cyc + rpar);
                if (issued == exp_q.size()) drain = 1;
            end
            if (was_drain != 0 && outst == 0) done_next = 1;
            exp_rdy = (drain == 0) && (outst < MAXOUT);
            @(negedge i_clk);
            cyc++;
        end
        ctl_ack = 1'b0;
        i_retire = 1'b0;
        checks++;
        if (done_next == 0) begin
            errors++;
            $display("FAIL pass_timeout: issued %0d of %0d tokens", issued, exp_q.size());
        end else if (o_done !== 1'b1 || o_busy !== 1'b0 || cfg_ack !== 1'b1 || ctl_rdy !== 1'b0) begin
            errors++;
            $display("FAIL pass_end: done=%b busy=%b cfg_ack=%b ctl_rdy=%b want 1 0 1 0", o_done, o_busy, cfg_ack, ctl_rdy);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (ctl_rdy !== 1'b0 || cfg_ack !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 ||
            o_err !== 1'b0 || o_ctl !== '0) begin
            errors++;
            $display("FAIL %s: rdy=%b ack=%b busy=%b done=%b err=%b ctl=%h want 0 1 0 0 0 0", tag, ctl_rdy, cfg_ack, o_busy, o_done, o_err, o_ctl);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset_state");
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_reset_outputs("post_reset_idle");
    endtask

    task automatic test_basic();
        run_pass(2, 1, 0, 0, 0, 100, 3);
    endtask

    task automatic test_d16_zero_taps();
        run_pass(0, 0, 1, 1, 0, 100, 2);
    endtask

    task automatic test_credit();
        run_pass(7, 0, 0, 0, 2, 100, 0);
    endtask

    task automatic test_stall_random();
        for (int n = 0; n < 6; n++) begin
            run_pass($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                     $urandom_range(0, 1), 1, 60, 50);
        end
    endtask

    task automatic test_back_to_back();
        run_pass(1, 2, 1, 0, 0, 100, 1);
        run_pass(3, 0, 0, 1, 0, 100, 5);
    endtask

    task automatic test_err();
        i_retire = 1'b1;
        @(negedge i_clk);
        i_retire = 1'b0;
        exp_err = 1;
        checks++;
        if (o_err !== 1'b1 || o_busy !== 1'b0 || ctl_rdy !== 1'b0) begin
            errors++;
            $display("FAIL err_idle_retire: err=%b busy=%b rdy=%b want 1 0 0", o_err, o_busy, ctl_rdy);
        end
        @(negedge i_clk);
        run_pass(1, 1, 0, 0, 2, 100, 0);
    endtask

    task automatic test_reset_mid();
        cfg_rdy = 1'b1;
        i_num_tap = 4'd7;
        i_num_out = 8'd0;
        i_psum_mode = 1'b0;
        i_psum_init = 1'b0;
        @(negedge i_clk);
        cfg_rdy = 1'b0;
        ctl_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ctl_rdy !== 1'b1 || o_ctl.tap_idx !== 4'(k)) begin
                errors++;
                $display("FAIL mid_tok %0d: rdy=%b tap=%0d want 1 %0d", k, ctl_rdy, o_ctl.tap_idx, k);
            end
            @(negedge i_clk);
        end
        ctl_ack = 1'b0;
        i_rst_n = 1'b0;
        #1;
        exp_err = 0;
        check_reset_outputs("reset_mid_run");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        run_pass(2, 0, 0, 1, 1, 70, 40);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_d16_zero_taps();
        test_credit();
        test_stall_random();
        test_back_to_back();
        test_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
